arb_crossbar: RTL and testbench
===============================

ARB_CROSSBAR -- requirements
Module: arb_crossbar

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: message width, including the destination field.
REQ-002 SHALL have parameter N_INPUTS, default 4: number of input ports, at least 2.
REQ-003 SHALL have parameter N_OUTPUTS, default 4: number of output ports, at least 2.
REQ-004 SHALL define DW = $clog2(N_OUTPUTS) and IW = $clog2(N_INPUTS).
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port recv_msg, input, BIT_WIDTH x N_INPUTS: input messages.
REQ-008 SHALL have port recv_val, input, 1 x N_INPUTS: input valid.
REQ-009 SHALL have port recv_rdy, output, 1 x N_INPUTS: input ready.
REQ-010 SHALL have port send_msg, output, BIT_WIDTH x N_OUTPUTS: output messages.
REQ-011 SHALL have port send_val, output, 1 x N_OUTPUTS: output valid.
REQ-012 SHALL have port send_rdy, input, 1 x N_OUTPUTS: output ready.
REQ-013 SHALL have port drop_count, output, 16 bits: saturating count of dropped messages.

Function
REQ-014 SHALL take the destination of input i from recv_msg[i][BIT_WIDTH-1 -: DW].
REQ-015 SHALL transfer a message on a port only in a cycle where both val and rdy are high on that port.
REQ-016 SHALL raise a request from input i to output o when recv_val[i] is high and the destination equals o.
REQ-017 SHALL keep one IW-bit priority pointer ptr[o] per output; each output arbitrates independently.
REQ-018 SHALL grant output o, when unlocked, to the first requesting input found searching cyclically from ptr[o] upward.
REQ-019 SHALL set lock[o] when output o has a grant but its accepting stage is not ready.
REQ-020 SHALL, while lock[o] is set, hold the grant on the same input and ignore any other requests.
REQ-021 SHALL clear lock[o] on the transfer that completes the locked message.
REQ-022 SHALL, on each transfer from granted input g into output o's accepting stage, set ptr[o] to (g+1) mod N_INPUTS.
REQ-023 SHALL leave ptr[o] unchanged when no transfer occurs on output o.
REQ-024 SHALL drive recv_rdy[i] high only when input i holds the grant at its destination and that output's accepting stage is ready.
REQ-025 SHALL accept and discard an input whose destination is N_OUTPUTS or greater: recv_rdy high, one message per cycle.
REQ-026 SHALL, when several inputs drop in the same cycle, increment drop_count once per dropped message.
REQ-027 SHALL saturate drop_count at 16'hFFFF.
REQ-028 SHALL drive send_msg[o] to zero whenever send_val[o] is low.
REQ-029 SHALL let different outputs transfer in the same cycle, giving N_OUTPUTS messages per cycle peak throughput.

Reset
REQ-030 SHALL, while reset is high, clear every ptr[o], every lock[o], drop_count and any pipeline registers.
REQ-031 SHALL hold all send_val and recv_rdy low while reset is high.
REQ-032 SHALL discard any message partially held at reset mid-operation.
REQ-033 SHALL accept requests on the first cycle after reset deasserts.

Configuration
REQ-034 SHALL add one output register per output when the macro ARB_CROSSBAR_OUT_REG_EN is defined.
REQ-035 SHALL, with ARB_CROSSBAR_OUT_REG_EN defined, make the register the accepting stage and let it load when empty or when its contents drain in the same cycle.
REQ-036 SHALL, with ARB_CROSSBAR_OUT_REG_EN defined, drive send_val and send_msg from the register, giving 1-cycle latency at full throughput.
REQ-037 SHALL, without ARB_CROSSBAR_OUT_REG_EN, make send_rdy the accepting stage.
REQ-038 SHALL, without ARB_CROSSBAR_OUT_REG_EN, drive send_msg/send_val combinationally from the granted input with 0-cycle latency.

Verification
Bench configuration: N_INPUTS=4, N_OUTPUTS=4, BIT_WIDTH=32, destination field in bits [31:30].
REQ-039 SHALL verify: inputs 0..3 each send 32'h4000_000i with send_rdy[1]=1 throughout -> output 1 emits inputs 0,1,2,3 in order, then ptr[1]=0.
REQ-040 SHALL verify: input 2 granted to output 3 with send_rdy[3]=0 for 5 cycles while input 0 also requests output 3 -> input 2's message is emitted first, unchanged; input 0 follows.
REQ-041 SHALL verify: four inputs each target a distinct output, all send_rdy=1 -> four transfers in the same cycle (latency 0 without the macro, 1 with it).
REQ-042 SHALL verify: N_OUTPUTS=3 with destination 2'b11 on input 1 for 3 cycles -> recv_rdy[1]=1 each cycle, drop_count=3, no send_val.
REQ-043 SHALL verify: reset asserted mid-stall with ARB_CROSSBAR_OUT_REG_EN defined -> next cycle all send_val=0, drop_count=0, ptr all 0.
REQ-044 SHALL verify: with ARB_CROSSBAR_OUT_REG_EN defined, continuous traffic to output 0 with send_rdy=1 -> one message per cycle, no bubbles.

Source files
------------

// File: rtl/arb_crossbar_if.sv
// Handshake bundle for arb_crossbar: N_INPUTS receive ports and N_OUTPUTS send ports.
interface arb_crossbar_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 4
);
    logic [N_INPUTS-1:0][BIT_WIDTH-1:0]  recv_msg;
    logic [N_INPUTS-1:0]                 recv_val;
    logic [N_INPUTS-1:0]                 recv_rdy;
    logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] send_msg;
    logic [N_OUTPUTS-1:0]                send_val;
    logic [N_OUTPUTS-1:0]                send_rdy;

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_val
    );

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg, send_val
    );
endinterface

// File: rtl/arb_crossbar.sv
// Crossbar with independent round-robin arbitration per output, grant lock while stalled,
// and a saturating count of messages dropped for out-of-range destinations.
// Define ARB_CROSSBAR_OUT_REG_EN to add a registered output stage per output.
module arb_crossbar #(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 4
) (
    input  logic          clk,
    input  logic          reset,
    arb_crossbar_if.slave bus,
    output logic [15:0]   drop_count
);
    localparam int DW = $clog2(N_OUTPUTS);
    localparam int IW = $clog2(N_INPUTS);

    logic [N_INPUTS-1:0][DW-1:0]        dest;
    logic [N_INPUTS-1:0]                drop;
    logic [N_OUTPUTS-1:0][N_INPUTS-1:0] req;

    logic [N_OUTPUTS-1:0][IW-1:0] ptr_q, ptr_d;
    logic [N_OUTPUTS-1:0]         lock_q, lock_d;
    logic [N_OUTPUTS-1:0][IW-1:0] lidx_q, lidx_d;
    logic [15:0]                  drop_cnt_q, drop_cnt_d;

    logic [N_OUTPUTS-1:0]         gnt_val;
    logic [N_OUTPUTS-1:0][IW-1:0] gnt_idx;
    logic [IW-1:0]                cand;
    logic [N_OUTPUTS-1:0]         acc_rdy;
    logic [N_OUTPUTS-1:0]         xfer;
    int                           drop_sum;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        dest = '0;
        drop = '0;
        req  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            dest[i] = bus.recv_msg[i][BIT_WIDTH-1 -: DW];
            if (int'(dest[i]) >= N_OUTPUTS) drop[i] = bus.recv_val[i];
            else                            req[dest[i]][i] = bus.recv_val[i];
        end
    end

    // A locked output stays on its stalled input; otherwise search cyclically from ptr.
    always_comb begin
        gnt_val = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            if (lock_q[o]) begin
                gnt_idx[o] = lidx_q[o];
                gnt_val[o] = req[o][lidx_q[o]];
            end else begin
                for (int k = 0; k < N_INPUTS; k++) begin
                    cand = IW'((int'(ptr_q[o]) + k) % N_INPUTS);
                    if (!gnt_val[o] && req[o][cand]) begin
                        gnt_val[o] = 1'b1;
                        gnt_idx[o] = cand;
                    end
                end
            end
        end
    end

    assign xfer = gnt_val & acc_rdy & {N_OUTPUTS{!reset}};

    always_comb begin
        bus.recv_rdy = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (!reset) begin
                if (int'(dest[i]) >= N_OUTPUTS) bus.recv_rdy[i] = 1'b1;
                else bus.recv_rdy[i] = xfer[dest[i]] && (gnt_idx[dest[i]] == IW'(i));
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        lock_d = lock_q;
        lidx_d = lidx_q;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            if (xfer[o]) begin
                ptr_d[o]  = (gnt_idx[o] == IW'(N_INPUTS - 1)) ? '0 : gnt_idx[o] + 1'b1;
                lock_d[o] = 1'b0;
            end else if (gnt_val[o]) begin
                lock_d[o] = 1'b1;
                lidx_d[o] = gnt_idx[o];
            end
        end
    end

    always_comb begin
        drop_sum = int'(drop_cnt_q);
        for (int i = 0; i < N_INPUTS; i++) drop_sum = drop_sum + int'(drop[i]);
        drop_cnt_d = (drop_sum > 65535) ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= '0;
            lidx_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lidx_q     <= lidx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;

`ifdef ARB_CROSSBAR_OUT_REG_EN
    logic [N_OUTPUTS-1:0]                oval_q, oval_d;
    logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] omsg_q, omsg_d;

    // The register accepts when empty or when its current word drains this cycle.
    assign acc_rdy = ~oval_q | bus.send_rdy;

    always_comb begin
        oval_d = oval_q;
        omsg_d = omsg_q;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            if (xfer[o]) begin
                oval_d[o] = 1'b1;
                omsg_d[o] = bus.recv_msg[gnt_idx[o]];
            end else if (bus.send_rdy[o]) begin
                oval_d[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the data words are reset as well, so a message caught mid-stall cannot resurface.
        if (reset) begin
            oval_q <= '0;
            omsg_q <= '0;
        end else begin
            oval_q <= oval_d;
            omsg_q <= omsg_d;
        end
    end

    assign bus.send_val = oval_q & {N_OUTPUTS{!reset}};

    always_comb begin
        bus.send_msg = '0;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            if (bus.send_val[o]) bus.send_msg[o] = omsg_q[o];
        end
    end
`else
    assign acc_rdy = bus.send_rdy;

    always_comb begin
        bus.send_val = '0;
        bus.send_msg = '0;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            bus.send_val[o] = gnt_val[o] && !reset;
            if (bus.send_val[o]) bus.send_msg[o] = bus.recv_msg[gnt_idx[o]];
        end
    end
`endif

endmodule

// File: tb/tb_arb_crossbar.sv
// Directed bench for arb_crossbar: a 4x4 instance plus a 4x3 instance for dropped destinations.
module tb_arb_crossbar;
`ifdef ARB_CROSSBAR_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] drop_count;
    logic [15:0] drop_count3;

    arb_crossbar_if #(.BIT_WIDTH(32), .N_INPUTS(4), .N_OUTPUTS(4)) bif ();
    arb_crossbar_if #(.BIT_WIDTH(32), .N_INPUTS(4), .N_OUTPUTS(3)) bif3 ();

    arb_crossbar #(.BIT_WIDTH(32), .N_INPUTS(4), .N_OUTPUTS(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bif),
        .drop_count (drop_count)
    );

    arb_crossbar #(.BIT_WIDTH(32), .N_INPUTS(4), .N_OUTPUTS(3)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bif3),
        .drop_count (drop_count3)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  mon_o = 2'd0;
    logic [31:0] emitted[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] em(input int k);
        return (k < emitted.size()) ? emitted[k] : 32'hDEAD_DEAD;
    endfunction

    // One clock of the 4x4 bench: log output mon_o transfers, retire accepted input messages.
    task automatic cycle();
        logic [3:0] acc;
        #1;
        acc = bif.recv_val & bif.recv_rdy;
        if (bif.send_val[mon_o] && bif.send_rdy[mon_o]) emitted.push_back(bif.send_msg[mon_o]);
        @(posedge clk);
        #1;
        bif.recv_val = bif.recv_val & ~acc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bif.recv_msg  = '0;
        bif.recv_val  = '0;
        bif.send_rdy  = '0;
        bif3.recv_msg = '0;
        bif3.recv_val = '0;
        bif3.send_rdy = '0;
        tick();
        tick();

        // Reset: outputs held low even with live requests
        for (int i = 0; i < 4; i++) bif.recv_msg[i] = 32'h4000_0000 + i;
        bif.recv_val = 4'hF;
        bif.send_rdy = 4'b0010;
        #1;
        check("rst_recv_rdy", bif.recv_rdy, 32'h0);
        check("rst_send_val", bif.send_val, 32'h0);
        tick();
        check("rst_ptr", u_dut.ptr_q, 32'h0);
        check("rst_drop", drop_count3, 32'h0);

        // Round robin on output 1, accepted from the first cycle after reset
        reset = 1'b0;
        mon_o = 2'd1;
        emitted.delete();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("A_recv_rdy", bif.recv_rdy, 32'(1 << k));
            cycle();
        end
        cycle();
        cycle();
        check("A_count", emitted.size(), 32'd4);
        for (int k = 0; k < 4; k++) check("A_order", em(k), 32'h4000_0000 + k);
        check("A_ptr1", u_dut.ptr_q[1], 32'h0);

        // Lock on output 3: input 2 stalled while input 0 competes
        bif.send_rdy    = 4'b0000;
        mon_o           = 2'd3;
        emitted.delete();
        bif.recv_msg[2] = 32'hC000_0022;
        bif.recv_val[2] = 1'b1;
        cycle();
        bif.recv_msg[0] = 32'hC000_0011;
        bif.recv_val[0] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("B_hold_msg", bif.send_msg[3], 32'hC000_0022);
            check("B_hold_rdy0", bif.recv_rdy[0], 32'h0);
            cycle();
        end
        check("B_none_yet", emitted.size(), 32'd0);
        bif.send_rdy[3] = 1'b1;
        repeat (4) cycle();
        check("B_count", emitted.size(), 32'd2);
        check("B_first", em(0), 32'hC000_0022);
        check("B_second", em(1), 32'hC000_0011);

        // Four inputs to four distinct outputs in one cycle
        bif.send_rdy    = 4'hF;
        mon_o           = 2'd2;
        emitted.delete();
        bif.recv_msg[0] = 32'hC000_0100;
        bif.recv_msg[1] = 32'h8000_0101;
        bif.recv_msg[2] = 32'h4000_0102;
        bif.recv_msg[3] = 32'h0000_0103;
        bif.recv_val    = 4'hF;
        #1;
        check("C_recv_rdy", bif.recv_rdy, 32'hF);
        check("C_send_val_c0", bif.send_val, (LAT == 0) ? 32'hF : 32'h0);
        cycle();
        #1;
        check("C_send_val_c1", bif.send_val, (LAT == 1) ? 32'hF : 32'h0);
        check("C_send_msg0_c1", bif.send_msg[0], (LAT == 1) ? 32'h0000_0103 : 32'h0);
        cycle();
        check("C_out2", em(0), 32'h8000_0101);

        // Out-of-range destination on a 3-output crossbar is accepted and counted
        bif3.send_rdy    = 3'b111;
        bif3.recv_msg[1] = 32'hC000_0055;
        bif3.recv_val    = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("D_drop_rdy", bif3.recv_rdy[1], 32'h1);
            check("D_no_send", bif3.send_val, 32'h0);
            tick();
        end
        #1;
        check("D_drop3", drop_count3, 32'd3);
        bif3.recv_msg[0] = 32'hC000_0066;
        bif3.recv_val    = 4'b0011;
        #1;
        check("D_dual_rdy", bif3.recv_rdy[1:0], 32'h3);
        tick();
        bif3.recv_val = '0;
        #1;
        check("D_drop5", drop_count3, 32'd5);

        // Reset asserted while output 2 is stalled
        bif.send_rdy    = 4'b1011;
        mon_o           = 2'd2;
        emitted.delete();
        bif.recv_msg[1] = 32'h8000_0077;
        bif.recv_val    = 4'b0010;
        cycle();
        cycle();
        #1;
        check("E_stall_val", bif.send_val[2], 32'h1);
        reset        = 1'b1;
        bif.recv_val = 4'b0010;
        #1;
        check("E_rst_send_val", bif.send_val, 32'h0);
        check("E_rst_recv_rdy", bif.recv_rdy, 32'h0);
        tick();
        reset        = 1'b0;
        bif.recv_val = '0;
        bif.send_rdy = 4'hF;
        #1;
        check("E_post_send_val", bif.send_val, 32'h0);
        check("E_post_ptr", u_dut.ptr_q, 32'h0);
        check("E_post_lock", u_dut.lock_q, 32'h0);
        check("E_post_drop", drop_count3, 32'h0);
        cycle();
        cycle();
        check("E_discarded", emitted.size(), 32'd0);

        // Continuous stream to output 0 without bubbles
        mon_o = 2'd0;
        emitted.delete();
        for (int k = 0; k < 8; k++) begin
            bif.recv_msg[0] = 32'h0000_0A00 + k;
            bif.recv_val[0] = 1'b1;
            #1;
            check("F_recv_rdy", bif.recv_rdy[0], 32'h1);
            check("F_send_val", bif.send_val[0], (k >= LAT) ? 32'h1 : 32'h0);
            check("F_send_msg", bif.send_msg[0], (k >= LAT) ? 32'h0000_0A00 + k - LAT : 32'h0);
            cycle();
        end
        cycle();
        check("F_count", emitted.size(), 32'd8);
        check("F_last", em(7), 32'h0000_0A07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
